// File: rtl/stack_param_pkg.sv
// ---------------------------------------------------------------------------
// stack_pkg : shared definitions for the stack_param LIFO.
//   stack_cmd_e : 2-bit command encoding (NOP / PUSH / POP / GET)
//   mod_add     : (a + b) mod depth, operands assumed < depth
//   mod_sub     : (a - b) mod depth, operands assumed < depth
// The wrap is done with a conditional subtract/add of depth, never by bit
// truncation, so a non-power-of-two depth wraps correctly. Operands are
// carried at 32 bits, which is wider than any pointer used here.
// ---------------------------------------------------------------------------
package stack_pkg;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_PUSH = 2'b01,
        CMD_POP  = 2'b10,
        CMD_GET  = 2'b11
    } stack_cmd_e;

    function automatic logic [31:0] mod_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] depth);
        logic [31:0] sum;
        sum = a + b;
        if (sum >= depth) begin
            sum = sum - depth;
        end else begin
            sum = sum;
        end
        return sum;
    endfunction

    function automatic logic [31:0] mod_sub(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] depth);
        logic [31:0] diff;
        if (a >= b) begin
            diff = a - b;
        end else begin
            diff = a + depth - b;
        end
        return diff;
    endfunction

endpackage

// File: rtl/stack_param_if.sv
// ---------------------------------------------------------------------------
// stack_param_if : command/data bundle between the sequencer (master) and
// the stack (slave).
//   COMMAND, INDEX, DATA_IN          : master -> stack
//   DATA_OUT, OUT_VALID, ERROR,
//   COUNT, EMPTY, FULL               : stack -> master (all registered)
// ---------------------------------------------------------------------------
interface stack_param_if
    import stack_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 5,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) ();

    stack_cmd_e         COMMAND;
    logic [IDX_W-1:0]   INDEX;
    logic [WIDTH-1:0]   DATA_IN;
    logic [WIDTH-1:0]   DATA_OUT;
    logic               OUT_VALID;
    logic               ERROR;
    logic [CNT_W-1:0]   COUNT;
    logic               EMPTY;
    logic               FULL;

    modport master (
        output COMMAND, INDEX, DATA_IN,
        input  DATA_OUT, OUT_VALID, ERROR, COUNT, EMPTY, FULL
    );

    modport slave (
        input  COMMAND, INDEX, DATA_IN,
        output DATA_OUT, OUT_VALID, ERROR, COUNT, EMPTY, FULL
    );

endinterface

// File: rtl/stack_param_ring_ptr.sv
// ---------------------------------------------------------------------------
// stack_ring_ptr : top-of-stack pointer for a DEPTH-entry ring.
//   clk_i, rst_ni : clock, synchronous active-low reset (top -> 0)
//   inc_i, dec_i  : advance / retreat top by one (mod DEPTH); inc wins
//   offset_i      : read offset below the top entry (0 = top entry)
//   top_o         : next free slot (write address)
//   rd_addr_o     : (top - 1 - offset) mod DEPTH, combinational
// ---------------------------------------------------------------------------
module stack_ring_ptr
    import stack_pkg::*;
#(
    parameter int DEPTH = 5,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic [IDX_W-1:0] offset_i,
    output logic [IDX_W-1:0] top_o,
    output logic [IDX_W-1:0] rd_addr_o
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    logic [IDX_W-1:0] top_q;
    logic [IDX_W-1:0] top_d;
    logic [31:0]      off_s;

    // Next pointer and read address; an offset beyond the ring is clamped so
    // the read address always stays inside the array (such GETs are rejected).
    always_comb begin
        if (32'(offset_i) < DEPTH_W) begin
            off_s = 32'(offset_i);
        end else begin
            off_s = 32'd0;
        end

        if (inc_i) begin
            top_d = IDX_W'(mod_add(32'(top_q), 32'd1, DEPTH_W));
        end else if (dec_i) begin
            top_d = IDX_W'(mod_sub(32'(top_q), 32'd1, DEPTH_W));
        end else begin
            top_d = top_q;
        end

        rd_addr_o = IDX_W'(mod_sub(mod_sub(32'(top_q), 32'd1, DEPTH_W),
                                   off_s, DEPTH_W));
    end

    // Pointer register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            top_q <= '0;
        end else begin
            top_q <= top_d;
        end
    end

    assign top_o = top_q;

endmodule

// File: rtl/stack_param.sv
// ---------------------------------------------------------------------------
// stack_param : parametrised LIFO stack, one command per clock, 1-cycle
// latency on every result.
//   CLK   : clock, all state changes on the rising edge
//   RESET : synchronous active-low reset (priority over any command)
//   bus   : stack_param_if.slave (COMMAND/INDEX/DATA_IN in,
//           DATA_OUT/OUT_VALID/ERROR/COUNT/EMPTY/FULL out, all registered)
// Optional build macro STACK_OVERFLOW_WRAP_EN: a PUSH while FULL overwrites
// the oldest entry instead of being rejected with ERROR.
// Array contents are not reset; they are unreachable until rewritten.
// ---------------------------------------------------------------------------
module stack_param
    import stack_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 5,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RESET,
    stack_param_if.slave  bus
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0] top_s;
    logic [IDX_W-1:0] rd_addr_s;
    logic [IDX_W-1:0] offset_s;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic             get_ok_s;
    logic             err_s;

    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;

    stack_ring_ptr #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ptr (
        .clk_i     (CLK),
        .rst_ni    (RESET),
        .inc_i     (push_ok_s),
        .dec_i     (pop_ok_s),
        .offset_i  (offset_s),
        .top_o     (top_s),
        .rd_addr_o (rd_addr_s)
    );

    // Command decode: classify the current command as accepted or rejected.
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        get_ok_s  = 1'b0;
        err_s     = 1'b0;
        offset_s  = bus.INDEX;
        case (bus.COMMAND)
            CMD_PUSH: begin
                if (!full_q) begin
                    push_ok_s = 1'b1;
                end else begin
`ifdef STACK_OVERFLOW_WRAP_EN
                    push_ok_s = 1'b1;
`else
                    err_s     = 1'b1;
`endif
                end
            end
            CMD_POP: begin
                offset_s = '0;
                if (!empty_q) begin
                    pop_ok_s = 1'b1;
                end else begin
                    err_s    = 1'b1;
                end
            end
            CMD_GET: begin
                if (32'(bus.INDEX) < 32'(count_q)) begin
                    get_ok_s = 1'b1;
                end else begin
                    err_s    = 1'b1;
                end
            end
            default: begin
                err_s = 1'b0;
            end
        endcase
    end

    // Next-state for count, flags and output registers.
    always_comb begin
        // A wrapping push while full leaves COUNT at DEPTH.
        if (push_ok_s && !full_q) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
        empty_d = (count_d == CNT_W'(0));
        full_d  = (count_d == CNT_W'(DEPTH));

        if (pop_ok_s || get_ok_s) begin
            data_out_d = mem_q[rd_addr_s];
        end else begin
            data_out_d = data_out_q;
        end
        valid_d = pop_ok_s || get_ok_s;
        error_d = err_s;
    end

    // Status and output registers.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    // Storage array; a push in the same cycle as reset is discarded.
    always_ff @(posedge CLK) begin
        if (RESET && push_ok_s) begin
            mem_q[top_s] <= bus.DATA_IN;
        end else begin
            mem_q[top_s] <= mem_q[top_s];
        end
    end

    assign bus.DATA_OUT  = data_out_q;
    assign bus.OUT_VALID = valid_q;
    assign bus.ERROR     = error_q;
    assign bus.COUNT     = count_q;
    assign bus.EMPTY     = empty_q;
    assign bus.FULL      = full_q;

endmodule

// File: tb/tb_stack_param.sv
// ---------------------------------------------------------------------------
// tb_stack_param : directed bench for stack_param. Two instances share the
// clock and reset: a 5 x 4-bit stack and a 6 x 8-bit stack (non-power-of-two
// ring). Expected values are hand-computed; STACK_OVERFLOW_WRAP_EN selects
// the overflow expectations.
// ---------------------------------------------------------------------------
module tb_stack_param;
    import stack_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    logic [3:0] x;
    logic [7:0] top6;

    always #5 clk = ~clk;

    stack_param_if #(.WIDTH(4), .DEPTH(5)) b5 ();
    stack_param_if #(.WIDTH(8), .DEPTH(6)) b6 ();

    stack_param #(.WIDTH(4), .DEPTH(5)) dut5 (.CLK(clk), .RESET(rst_n), .bus(b5.slave));
    stack_param #(.WIDTH(8), .DEPTH(6)) dut6 (.CLK(clk), .RESET(rst_n), .bus(b6.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic s5(input stack_cmd_e c, input logic [2:0] idx, input logic [3:0] d);
        b5.COMMAND = c; b5.INDEX = idx; b5.DATA_IN = d;
        @(posedge clk); #1;
        b5.COMMAND = CMD_NOP;
    endtask

    task automatic s6(input stack_cmd_e c, input logic [2:0] idx, input logic [7:0] d);
        b6.COMMAND = c; b6.INDEX = idx; b6.DATA_IN = d;
        @(posedge clk); #1;
        b6.COMMAND = CMD_NOP;
    endtask

    initial begin
        b5.COMMAND = CMD_NOP; b5.INDEX = 3'd0; b5.DATA_IN = 4'd0;
        b6.COMMAND = CMD_NOP; b6.INDEX = 3'd0; b6.DATA_IN = 8'd0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset state
        chk("rst_count", 32'(b5.COUNT), 32'd0);
        chk("rst_empty", 32'(b5.EMPTY), 32'd1);
        chk("rst_full",  32'(b5.FULL),  32'd0);
        chk("rst_dout",  32'(b5.DATA_OUT), 32'd0);
        chk("rst_valid", 32'(b5.OUT_VALID), 32'd0);
        chk("rst_error", 32'(b5.ERROR), 32'd0);

        // Underflow: POP and GET on an empty stack
        s5(CMD_POP, 3'd0, 4'd0);
        chk("pop_empty_err",   32'(b5.ERROR), 32'd1);
        chk("pop_empty_dout",  32'(b5.DATA_OUT), 32'd0);
        chk("pop_empty_count", 32'(b5.COUNT), 32'd0);
        chk("pop_empty_valid", 32'(b5.OUT_VALID), 32'd0);
        s5(CMD_GET, 3'd0, 4'd0);
        chk("get_empty_err", 32'(b5.ERROR), 32'd1);
        s5(CMD_NOP, 3'd0, 4'd0);
        chk("nop_err_clear", 32'(b5.ERROR), 32'd0);

        // Push 3,7,9 then GET 0/1/2
        s5(CMD_PUSH, 3'd0, 4'd3);
        s5(CMD_PUSH, 3'd0, 4'd7);
        s5(CMD_PUSH, 3'd0, 4'd9);
        chk("p3_count", 32'(b5.COUNT), 32'd3);
        chk("p3_empty", 32'(b5.EMPTY), 32'd0);
        chk("p3_full",  32'(b5.FULL),  32'd0);
        chk("p3_valid", 32'(b5.OUT_VALID), 32'd0);
        s5(CMD_GET, 3'd0, 4'd0);
        chk("get0", 32'(b5.DATA_OUT), 32'd9);
        chk("get0_v", 32'(b5.OUT_VALID), 32'd1);
        s5(CMD_GET, 3'd1, 4'd0);
        chk("get1", 32'(b5.DATA_OUT), 32'd7);
        chk("get1_v", 32'(b5.OUT_VALID), 32'd1);
        s5(CMD_GET, 3'd2, 4'd0);
        chk("get2", 32'(b5.DATA_OUT), 32'd3);
        chk("get2_v", 32'(b5.OUT_VALID), 32'd1);
        s5(CMD_GET, 3'd3, 4'd0);
        chk("get3_err",  32'(b5.ERROR), 32'd1);
        chk("get3_hold", 32'(b5.DATA_OUT), 32'd3);
        chk("get3_v",    32'(b5.OUT_VALID), 32'd0);
        chk("get_count", 32'(b5.COUNT), 32'd3);

        // Pop them back
        s5(CMD_POP, 3'd0, 4'd0);
        chk("pop9", 32'(b5.DATA_OUT), 32'd9);
        chk("pop9_cnt", 32'(b5.COUNT), 32'd2);
        s5(CMD_POP, 3'd0, 4'd0);
        chk("pop7", 32'(b5.DATA_OUT), 32'd7);
        s5(CMD_POP, 3'd0, 4'd0);
        chk("pop3", 32'(b5.DATA_OUT), 32'd3);
        chk("pop3_empty", 32'(b5.EMPTY), 32'd1);

        // PUSH then GET 0 immediately returns the new word
        s5(CMD_PUSH, 3'd0, 4'hE);
        s5(CMD_GET, 3'd0, 4'd0);
        chk("push_get0", 32'(b5.DATA_OUT), 32'hE);
        s5(CMD_POP, 3'd0, 4'd0);
        chk("push_get_pop", 32'(b5.DATA_OUT), 32'hE);

        // Fill 1..5, then overflow with 6
        for (int i = 1; i <= 5; i++) begin
            s5(CMD_PUSH, 3'd0, 4'(i));
        end
        chk("fill_full",  32'(b5.FULL),  32'd1);
        chk("fill_count", 32'(b5.COUNT), 32'd5);
        s5(CMD_PUSH, 3'd0, 4'd6);
        chk("ovf_count", 32'(b5.COUNT), 32'd5);
        chk("ovf_full",  32'(b5.FULL),  32'd1);
`ifdef STACK_OVERFLOW_WRAP_EN
        chk("ovf_err", 32'(b5.ERROR), 32'd0);
        for (int k = 0; k < 5; k++) begin
            s5(CMD_POP, 3'd0, 4'd0);
            chk("ovf_pop", 32'(b5.DATA_OUT), 32'(6 - k));
        end
`else
        chk("ovf_err", 32'(b5.ERROR), 32'd1);
        for (int k = 0; k < 5; k++) begin
            s5(CMD_POP, 3'd0, 4'd0);
            chk("ovf_pop", 32'(b5.DATA_OUT), 32'(5 - k));
        end
`endif
        chk("drain_empty", 32'(b5.EMPTY), 32'd1);
        chk("drain_count", 32'(b5.COUNT), 32'd0);

        // Alternating PUSH x / POP for 20 cycles
        for (int k = 0; k < 10; k++) begin
            x = 4'($urandom_range(0, 15));
            s5(CMD_PUSH, 3'd0, x);
            chk("alt_cnt1", 32'(b5.COUNT), 32'd1);
            s5(CMD_POP, 3'd0, 4'd0);
            chk("alt_pop", 32'(b5.DATA_OUT), 32'(x));
            chk("alt_cnt0", 32'(b5.COUNT), 32'd0);
        end

        // Reset together with a PUSH discards everything
        s5(CMD_PUSH, 3'd0, 4'hA);
        s5(CMD_PUSH, 3'd0, 4'hB);
        chk("pre_rst_cnt", 32'(b5.COUNT), 32'd2);
        rst_n = 1'b0;
        s5(CMD_PUSH, 3'd0, 4'hC);
        rst_n = 1'b1;
        chk("mid_rst_count", 32'(b5.COUNT), 32'd0);
        chk("mid_rst_empty", 32'(b5.EMPTY), 32'd1);
        chk("mid_rst_valid", 32'(b5.OUT_VALID), 32'd0);
        chk("mid_rst_error", 32'(b5.ERROR), 32'd0);
        s5(CMD_POP, 3'd0, 4'd0);
        chk("post_rst_pop_err", 32'(b5.ERROR), 32'd1);
        chk("post_rst_dout",    32'(b5.DATA_OUT), 32'd0);

        // DEPTH=6, WIDTH=8: push 10..19 to exercise the ring wrap
        for (int i = 10; i < 20; i++) begin
            s6(CMD_PUSH, 3'd0, 8'(i));
        end
        chk("d6_count", 32'(b6.COUNT), 32'd6);
        chk("d6_full",  32'(b6.FULL),  32'd1);
`ifdef STACK_OVERFLOW_WRAP_EN
        chk("d6_last_err", 32'(b6.ERROR), 32'd0);
        top6 = 8'd19;
`else
        chk("d6_last_err", 32'(b6.ERROR), 32'd1);
        top6 = 8'd15;
`endif
        s6(CMD_GET, 3'd6, 8'd0);
        chk("d6_get6_err", 32'(b6.ERROR), 32'd1);
        s6(CMD_GET, 3'd7, 8'd0);
        chk("d6_get7_err", 32'(b6.ERROR), 32'd1);
        s6(CMD_GET, 3'd5, 8'd0);
        chk("d6_get5", 32'(b6.DATA_OUT), 32'(top6 - 8'd5));
        chk("d6_get5_v", 32'(b6.OUT_VALID), 32'd1);
        s6(CMD_GET, 3'd0, 8'd0);
        chk("d6_get0", 32'(b6.DATA_OUT), 32'(top6));
        for (int k = 0; k < 6; k++) begin
            s6(CMD_POP, 3'd0, 8'd0);
            chk("d6_pop", 32'(b6.DATA_OUT), 32'(top6 - 8'(k)));
        end
        chk("d6_empty", 32'(b6.EMPTY), 32'd1);
        s6(CMD_POP, 3'd0, 8'd0);
        chk("d6_under_err", 32'(b6.ERROR), 32'd1);
        s6(CMD_PUSH, 3'd0, 8'hA5);
        s6(CMD_GET, 3'd0, 8'd0);
        chk("d6_repush", 32'(b6.DATA_OUT), 32'hA5);
        chk("d6_repush_cnt", 32'(b6.COUNT), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
